// File: rtl/pc_seq_ras_pkg.sv
// Shared operation encoding for the fetch-path program counter.
// Codes 5-7 are left undefined on purpose; the PC treats them as SEQ.
package pc_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        SEQ  = 3'd0,
        JMP  = 3'd1,
        BR   = 3'd2,
        CALL = 3'd3,
        RET  = 3'd4
    } pc_op_e;

endpackage

// File: rtl/ras_stack.sv
// Circular LIFO of return addresses. Pushing while full overwrites the oldest
// entry, and popping while empty is ignored.
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               top,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int SP_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [SP_W-1:0]  SP_LAST = SP_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [W-1:0]    mem [DEPTH];
    logic [SP_W-1:0] sp;
    logic [SP_W-1:0] sp_inc;
    logic [SP_W-1:0] sp_dec;

    // sp points at the next free slot. When the stack is full, that slot holds the oldest entry.
    assign sp_inc = (sp == SP_LAST) ? '0 : sp + SP_W'(1);
    assign sp_dec = (sp == '0) ? SP_LAST : sp - SP_W'(1);

    assign top   = mem[sp_dec];
    assign full  = (count == CNT_MAX);
    assign empty = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[sp] <= din;
            sp      <= sp_inc;
            if (!full) begin
                count <= count + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            sp    <= sp_dec;
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_seq_ras.sv
// Configurable-width program counter for the fetch path. It supports step, jump,
// relative branch and call/return through a small return-address stack.
module pc_seq_ras
    import pc_pkg::*;
#(
    parameter int PC_W      = 6,
    parameter int OFF_W     = 6,
    parameter int STEP      = 1,
    parameter int RAS_DEPTH = 4,
    parameter int RESET_PC  = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [OP_W-1:0]                op,
    input  logic [PC_W-1:0]                target,
    input  logic [OFF_W-1:0]               offset,
    input  logic                           clr_err,
    output logic [PC_W-1:0]                pc,
    output logic [PC_W-1:0]                pc_next,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           ras_full,
    output logic                           ras_empty,
    output logic                           ras_ovf,
    output logic                           ras_unf
);

    generate
        if (OFF_W > PC_W) begin : g_bad_off_w
            $error("pc_seq_ras: OFF_W must not exceed PC_W");
        end
        if (RAS_DEPTH < 2) begin : g_bad_depth
            $error("pc_seq_ras: RAS_DEPTH must be at least 2");
        end
    endgenerate

    pc_op_e          op_e;
    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] br_pc;
    logic [PC_W-1:0] ret_addr;
    logic [PC_W-1:0] op_pc;
    logic            is_call;
    logic            is_ret;

    assign op_e = pc_op_e'(op);

    // Both sums wrap modulo 2^PC_W. The offset is sign-extended before it is added.
    assign seq_pc = pc + PC_W'(STEP);
    assign br_pc  = pc + PC_W'(signed'(offset));

    always_comb begin
        op_pc = seq_pc;
        case (op_e)
            JMP, CALL: op_pc = target;
            BR:        op_pc = br_pc;
            RET:       op_pc = ras_empty ? seq_pc : ret_addr;
            default:   op_pc = seq_pc;
        endcase
    end

    assign pc_next = en ? op_pc : pc;
    assign is_call = en && (op_e == CALL);
    assign is_ret  = en && (op_e == RET);

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (is_call),
        .pop   (is_ret),
        .din   (seq_pc),
        .top   (ret_addr),
        .count (ras_count),
        .full  (ras_full),
        .empty (ras_empty)
    );

    // The set is written after the clear, so an error on the same edge as clr_err still sticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= PC_W'(RESET_PC);
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
        end else begin
            if (en) begin
                pc <= pc_next;
            end
            if (clr_err) begin
                ras_ovf <= 1'b0;
                ras_unf <= 1'b0;
            end
            if (is_call && ras_full) begin
                ras_ovf <= 1'b1;
            end
            if (is_ret && ras_empty) begin
                ras_unf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_seq_ras.sv
// Directed bench for pc_seq_ras. The driver queues hand-computed expectations,
// and a monitor compares them against the DUT at each falling edge.
module tb_pc_seq_ras;
    import pc_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] op;
    logic [5:0] target;
    logic [5:0] offset;
    logic       clr_err;
    logic [5:0] pc;
    logic [5:0] pc_next;
    logic [2:0] ras_count;
    logic       ras_full;
    logic       ras_empty;
    logic       ras_ovf;
    logic       ras_unf;

    typedef struct {
        string      name;
        int         cyc;
        logic [5:0] pc;
        logic [5:0] pc_next;
        logic [2:0] cnt;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [2:0] exp_cnt = 3'd0;
    logic       exp_ovf = 1'b0;
    logic       exp_unf = 1'b0;

    pc_seq_ras #(
        .PC_W      (6),
        .OFF_W     (6),
        .STEP      (1),
        .RAS_DEPTH (4),
        .RESET_PC  (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .op        (op),
        .target    (target),
        .offset    (offset),
        .clr_err   (clr_err),
        .pc        (pc),
        .pc_next   (pc_next),
        .ras_count (ras_count),
        .ras_full  (ras_full),
        .ras_empty (ras_empty),
        .ras_ovf   (ras_ovf),
        .ras_unf   (ras_unf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pushExpect(input string name, input logic [5:0] epc, input logic [5:0] enext);
        exp_t x;
        x.name    = name;
        x.cyc     = cyc;
        x.pc      = epc;
        x.pc_next = enext;
        x.cnt     = exp_cnt;
        x.ovf     = exp_ovf;
        x.unf     = exp_unf;
        sb.push_back(x);
    endtask

    // Inputs set here take effect at the next rising edge. The expectation describes the current cycle.
    task automatic applyStimulus(input string name, input logic e, input pc_op_e o,
                                 input logic [5:0] t, input logic [5:0] off, input logic c,
                                 input logic [5:0] epc, input logic [5:0] enext);
        @(posedge clk);
        #1;
        en      = e;
        op      = o;
        target  = t;
        offset  = off;
        clr_err = c;
        pushExpect(name, epc, enext);
    endtask

    // Monitor
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                x = sb.pop_front();
                checkOutput({x.name, ".pc"}, 32'(pc), 32'(x.pc));
                checkOutput({x.name, ".pc_next"}, 32'(pc_next), 32'(x.pc_next));
                checkOutput({x.name, ".count"}, 32'(ras_count), 32'(x.cnt));
                checkOutput({x.name, ".full"}, 32'(ras_full), 32'(x.cnt == 3'd4));
                checkOutput({x.name, ".empty"}, 32'(ras_empty), 32'(x.cnt == 3'd0));
                checkOutput({x.name, ".ovf"}, 32'(ras_ovf), 32'(x.ovf));
                checkOutput({x.name, ".unf"}, 32'(ras_unf), 32'(x.unf));
            end
        end
    end

    initial begin
        int wait_cycles;
        rst = 1'b1; en = 1'b0; op = 3'd0; target = '0; offset = '0; clr_err = 1'b0;
        #2;
        pushExpect("reset", 6'd0, 6'd0);
        @(negedge clk);
        #1 rst = 1'b0;

        // Free-running step with wrap, ending at pc=12
        for (int i = 0; i < 76; i++) begin
            applyStimulus("seq", 1'b1, SEQ, 6'd0, 6'd0, 1'b0, 6'(i % 64), 6'((i + 1) % 64));
        end

        // Stall ignores op
        for (int i = 0; i < 3; i++) begin
            applyStimulus("stall", 1'b0, JMP, 6'd20, 6'd0, 1'b0, 6'd12, 6'd12);
        end
        applyStimulus("jmp20", 1'b1, JMP, 6'd20, 6'd0, 1'b0, 6'd12, 6'd20);

        // Relative branches, negative offset and wrap
        applyStimulus("jmp10", 1'b1, JMP, 6'd10, 6'd0, 1'b0, 6'd20, 6'd10);
        applyStimulus("br_neg", 1'b1, BR, 6'd0, 6'b111101, 1'b0, 6'd10, 6'd7);
        applyStimulus("jmp62", 1'b1, JMP, 6'd62, 6'd0, 1'b0, 6'd7, 6'd62);
        applyStimulus("br_wrap", 1'b1, BR, 6'd0, 6'd5, 1'b0, 6'd62, 6'd3);
        applyStimulus("rsvd7", 1'b1, pc_op_e'(3'd7), 6'd40, 6'd0, 1'b0, 6'd3, 6'd4);

        // Single call and return
        applyStimulus("jmp5", 1'b1, JMP, 6'd5, 6'd0, 1'b0, 6'd4, 6'd5);
        applyStimulus("call40", 1'b1, CALL, 6'd40, 6'd0, 1'b0, 6'd5, 6'd40);
        exp_cnt = 3'd1;
        applyStimulus("ret6", 1'b1, RET, 6'd0, 6'd0, 1'b0, 6'd40, 6'd6);
        exp_cnt = 3'd0;

        // Overflow: five calls into a four-entry stack
        applyStimulus("jmp0", 1'b1, JMP, 6'd0, 6'd0, 1'b0, 6'd6, 6'd0);
        applyStimulus("call_a", 1'b1, CALL, 6'd10, 6'd0, 1'b0, 6'd0, 6'd10);
        exp_cnt = 3'd1;
        applyStimulus("call_b", 1'b1, CALL, 6'd20, 6'd0, 1'b0, 6'd10, 6'd20);
        exp_cnt = 3'd2;
        applyStimulus("call_c", 1'b1, CALL, 6'd30, 6'd0, 1'b0, 6'd20, 6'd30);
        exp_cnt = 3'd3;
        applyStimulus("call_d", 1'b1, CALL, 6'd40, 6'd0, 1'b0, 6'd30, 6'd40);
        exp_cnt = 3'd4;
        applyStimulus("call_e", 1'b1, CALL, 6'd50, 6'd0, 1'b0, 6'd40, 6'd50);
        exp_ovf = 1'b1;
        applyStimulus("ret41", 1'b1, RET, 6'd0, 6'd0, 1'b0, 6'd50, 6'd41);
        exp_cnt = 3'd3;
        applyStimulus("ret31", 1'b1, RET, 6'd0, 6'd0, 1'b0, 6'd41, 6'd31);
        exp_cnt = 3'd2;
        applyStimulus("ret21", 1'b1, RET, 6'd0, 6'd0, 1'b0, 6'd31, 6'd21);
        exp_cnt = 3'd1;
        applyStimulus("ret11", 1'b1, RET, 6'd0, 6'd0, 1'b0, 6'd21, 6'd11);
        exp_cnt = 3'd0;
        applyStimulus("ret_empty", 1'b1, RET, 6'd0, 6'd0, 1'b0, 6'd11, 6'd12);
        exp_unf = 1'b1;
        applyStimulus("clr", 1'b0, SEQ, 6'd0, 6'd0, 1'b1, 6'd12, 6'd12);
        exp_ovf = 1'b0; exp_unf = 1'b0;

        // Set wins over a simultaneous clear
        applyStimulus("ret_clr", 1'b1, RET, 6'd0, 6'd0, 1'b1, 6'd12, 6'd13);
        exp_unf = 1'b1;
        applyStimulus("clr2", 1'b0, SEQ, 6'd0, 6'd0, 1'b1, 6'd13, 6'd13);
        exp_unf = 1'b0;

        // Async reset mid-cycle with live stack and flag
        applyStimulus("ret_e2", 1'b1, RET, 6'd0, 6'd0, 1'b0, 6'd13, 6'd14);
        exp_unf = 1'b1;
        applyStimulus("call6a", 1'b1, CALL, 6'd30, 6'd0, 1'b0, 6'd14, 6'd30);
        exp_cnt = 3'd1;
        applyStimulus("call6b", 1'b1, CALL, 6'd40, 6'd0, 1'b0, 6'd30, 6'd40);
        exp_cnt = 3'd2;
        @(posedge clk);
        #1 en = 1'b0; op = 3'd0; clr_err = 1'b0;
        #2 rst = 1'b1;
        exp_cnt = 3'd0; exp_ovf = 1'b0; exp_unf = 1'b0;
        pushExpect("async_rst", 6'd0, 6'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        applyStimulus("ret_rst", 1'b1, RET, 6'd0, 6'd0, 1'b0, 6'd0, 6'd1);
        exp_unf = 1'b1;
        applyStimulus("final", 1'b0, SEQ, 6'd0, 6'd0, 1'b0, 6'd1, 6'd1);

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
